sha256_msg_schedule: RTL and testbench



---
 rtl/sha256_pkg.sv | 23 ++
 rtl/sha256_msg_schedule.sv | 115 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word size, round count, schedule FSM states and
// the small-sigma functions used by the message schedule.
package sha256_pkg;

    localparam int unsigned WordWidth = 32;
    localparam int unsigned NumRounds = 64;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } msched_state_e;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: 16-word sliding window streaming W0..W63.
// Optional macro SHA256_BYTE_SWAP_EN byte-reverses each block word at load.
module sha256_msg_schedule #(
    parameter int unsigned BlockWidth = 512,
    parameter int unsigned WordWidth  = 32,
    parameter int unsigned NumRounds  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [BlockWidth-1:0] block_i,
    input  logic                  stall_i,
    output logic [WordWidth-1:0]  w_o,
    output logic                  w_valid_o,
    output logic [5:0]            round_o,
    output logic                  busy_o,
    output logic                  done_o
);
    import sha256_pkg::*;

    if (WordWidth != 32) begin : g_bad_word_width
        $error("sha256_msg_schedule: WordWidth must be 32");
    end
    if (BlockWidth != 16 * WordWidth) begin : g_bad_block_width
        $error("sha256_msg_schedule: BlockWidth must be 16 * WordWidth");
    end
    if (NumRounds < 1 || NumRounds > 64) begin : g_bad_rounds
        $error("sha256_msg_schedule: NumRounds must be in 1..64");
    end

    localparam logic [5:0] LastRound = 6'(NumRounds - 1);

    function automatic logic [WordWidth-1:0] load_word(input logic [WordWidth-1:0] x);
`ifdef SHA256_BYTE_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    msched_state_e        state_q, state_d;
    logic [WordWidth-1:0] win_q [16];
    logic [WordWidth-1:0] win_d [16];
    logic [5:0]           cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [WordWidth-1:0] w_new;

    // W[t+16] from the current window, where win_q[0] holds W[t].
    assign w_new = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    for (int j = 0; j < 16; j++) begin
                        win_d[j] = load_word(block_i[WordWidth*j +: WordWidth]);
                    end
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!stall_i) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = w_new;
                    if (cnt_q == LastRound) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything, including a start in the same cycle.
        if (clear_i) begin
            state_d = StIdle;
            win_d   = '{default: '0};
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            win_q   <= '{default: '0};
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign w_o       = win_q[0];
    assign w_valid_o = (state_q == StRun);
    assign busy_o    = (state_q == StRun);
    assign round_o   = cnt_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: "abc" block, stalls, back-to-back,
// start-while-busy and abort. Honours SHA256_BYTE_SWAP_EN for block encoding.
module tb_sha256_msg_schedule;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic         clear_i = 1'b0;
    logic [511:0] block_i = '0;
    logic         stall_i = 1'b0;
    logic [31:0]  w_o;
    logic         w_valid_o;
    logic [5:0]   round_o;
    logic         busy_o;
    logic         done_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  exp_w [64];
    logic [31:0]  obs_w [64];
    logic [511:0] abc_blk;
    logic [511:0] blk2;

    sha256_msg_schedule dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .clear_i   (clear_i),
        .block_i   (block_i),
        .stall_i   (stall_i),
        .w_o       (w_o),
        .w_valid_o (w_valid_o),
        .round_o   (round_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] x);
`ifdef SHA256_BYTE_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    task automatic build_sched(input logic [511:0] b);
        for (int j = 0; j < 16; j++) exp_w[j] = ref_load(b[32*j +: 32]);
        for (int t = 16; t < 64; t++)
            exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic start_blk(input logic [511:0] b);
        block_i = b;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Called at the sample point where W0 is presented; returns at the done cycle.
    task automatic run_stream(input int pct, input int inj_round);
        int t, cyc, stalls;
        bit s, done_early, injected;
        t = 0; cyc = 0; stalls = 0; done_early = 0; injected = 0;
        while (t < 64 && cyc < 1000) begin
            check_val($sformatf("valid[%0d]", t), 64'(w_valid_o), 64'd1);
            check_val($sformatf("busy[%0d]", t), 64'(busy_o), 64'd1);
            check_val($sformatf("w[%0d]", t), 64'(w_o), 64'(exp_w[t]));
            check_val($sformatf("round[%0d]", t), 64'(round_o), 64'(t));
            obs_w[t] = w_o;
            if (done_o) done_early = 1;
            s = (pct > 0) && ($urandom_range(99) < pct);
            stall_i = s;
            if (t == inj_round && !injected) begin
                injected = 1;
                block_i  = blk2;
                start_i  = 1'b1;
            end
            @(posedge clk_i); #1;
            cyc++;
            start_i = 1'b0;
            if (s) stalls++; else t++;
        end
        stall_i = 1'b0;
        check_val("stream_timeout", 64'(cyc < 1000), 64'd1);
        check_val("no_early_done", 64'(done_early), 64'd0);
        check_val("done_pulse", 64'(done_o), 64'd1);
        check_val("done_latency", 64'(cyc), 64'(64 + stalls));
        check_val("busy_after", 64'(busy_o), 64'd0);
        check_val("valid_after", 64'(w_valid_o), 64'd0);
    endtask

    initial begin
        bit done_seen;
        logic [31:0] wv;

        abc_blk = '0;
`ifdef SHA256_BYTE_SWAP_EN
        abc_blk[31:0]    = 32'h80636261;
        abc_blk[511:480] = 32'h18000000;
`else
        abc_blk[31:0]    = 32'h61626380;
        abc_blk[511:480] = 32'h00000018;
`endif
        for (int j = 0; j < 16; j++) begin
            wv = 32'(32'h11111111 * (j + 1));
            blk2[32*j +: 32] = wv;
        end

        // Reset
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_w", 64'(w_o), 64'd0);
        check_val("rst_valid", 64'(w_valid_o), 64'd0);
        check_val("rst_round", 64'(round_o), 64'd0);
        check_val("rst_busy", 64'(busy_o), 64'd0);
        check_val("rst_done", 64'(done_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // "abc" block, no stalls, with hand-computed words
        build_sched(abc_blk);
        start_blk(abc_blk);
        run_stream(0, -1);
        check_val("abc_w0", 64'(obs_w[0]), 64'h61626380);
        check_val("abc_w15", 64'(obs_w[15]), 64'h00000018);
        check_val("abc_w16", 64'(obs_w[16]), 64'h61626380);
        check_val("abc_w17", 64'(obs_w[17]), 64'h000F0000);
        @(posedge clk_i); #1;
        check_val("done_one_cycle", 64'(done_o), 64'd0);

        // Random ~30% stalls
        start_blk(abc_blk);
        run_stream(30, -1);

        // Back-to-back: start in the done cycle
        build_sched(blk2);
        start_blk(blk2);
        check_val("b2b_busy", 64'(busy_o), 64'd1);
        run_stream(0, -1);

        // Start while busy at round 20 is ignored
        build_sched(abc_blk);
        start_blk(abc_blk);
        run_stream(0, 20);

        // Abort at round 30 with a simultaneous start
        start_blk(abc_blk);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i); #1;
        end
        check_val("abort_round", 64'(round_o), 64'd30);
        check_val("abort_w30", 64'(w_o), 64'(exp_w[30]));
        clear_i = 1'b1;
        start_i = 1'b1;
        block_i = blk2;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        start_i = 1'b0;
        check_val("clr_w", 64'(w_o), 64'd0);
        check_val("clr_valid", 64'(w_valid_o), 64'd0);
        check_val("clr_round", 64'(round_o), 64'd0);
        check_val("clr_busy", 64'(busy_o), 64'd0);
        check_val("clr_done", 64'(done_o), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) done_seen = 1;
        end
        check_val("abort_quiet", 64'(done_seen), 64'd0);

        // Clean schedule after abort
        start_blk(abc_blk);
        run_stream(0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
